alu_top: RTL and testbench

- Board-level wrapper around an 8-bit combinational ALU.
- Three push-buttons capture the slide-switch value into operand A, operand B or the opcode register.
- The ALU result is registered and driven onto the LEDs.
- Contains the input registers, the ALU (may be a separate submodule) and the output register.

---
 rtl/alu_top.sv | 95 +++++++++
 tb/tb_alu_top.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
// Board wrapper: push-buttons capture the switch value into operand A, operand B
// or the opcode register, and the registered result of the 8-bit ALU drives the LEDs.
module alu_top #(
  parameter int NB_SW   = 8,
  parameter int NB_BTN  = 3,
  parameter int NB_LEDS = 8,
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic [NB_LEDS-1:0] o_led
);

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

  localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

  logic [NB_DATA-1:0] a_r;
  logic [NB_DATA-1:0] b_r;
  logic [NB_OP-1:0]   op_r;
  logic [NB_DATA-1:0] result_s;
  logic               shift_over_s;
  logic [NB_LEDS-1:0] led_r;

  // Operand and opcode capture; each button is a level enable, reset wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_r  <= {NB_DATA{1'b0}};
      b_r  <= {NB_DATA{1'b0}};
      op_r <= {NB_OP{1'b0}};
    end else begin
      if (i_btn[0]) begin
        a_r <= i_sw[NB_DATA-1:0];
      end
      if (i_btn[1]) begin
        b_r <= i_sw[NB_DATA-1:0];
      end
      if (i_btn[2]) begin
        op_r <= i_sw[NB_OP-1:0];
      end
    end
  end

  // Combinational ALU on the registered operands; unknown opcodes yield zero.
  always_comb begin
    result_s     = {NB_DATA{1'b0}};
    shift_over_s = (b_r >= SHIFT_LIMIT);
    case (op_r)
      OP_ADD:  result_s = a_r + b_r;
      OP_SUB:  result_s = a_r - b_r;
      OP_AND:  result_s = a_r & b_r;
      OP_OR:   result_s = a_r | b_r;
      OP_XOR:  result_s = a_r ^ b_r;
      OP_NOR:  result_s = ~(a_r | b_r);
      OP_SRL: begin
        if (shift_over_s) begin
          result_s = {NB_DATA{1'b0}};
        end else begin
          result_s = a_r >> b_r;
        end
      end
      OP_SRA: begin
        // Oversized arithmetic shifts saturate to a full sign fill.
        if (shift_over_s) begin
          result_s = {NB_DATA{a_r[NB_DATA-1]}};
        end else begin
          result_s = $unsigned($signed(a_r) >>> b_r);
        end
      end
      default: result_s = {NB_DATA{1'b0}};
    endcase
  end

  // Output register keeps the LEDs glitch-free between edges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      led_r <= {NB_LEDS{1'b0}};
    end else begin
      led_r <= result_s;
    end
  end

  assign o_led = led_r;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed spec scenarios plus randomized
// loads checked against an arithmetic reference model.
module tb_alu_top;

  logic       i_clk;
  logic       i_reset;
  logic [7:0] i_sw;
  logic [2:0] i_btn;
  logic [7:0] o_led;

  int n_checks;
  int n_fail;

  // Reference state: what A, B, op hold and what o_led must show now.
  int m_a, m_b, m_op;
  int exp_led;

  alu_top dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .i_btn   (i_btn),
    .o_led   (o_led)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int ref_alu(int a, int b, int op);
    int r;
    int sa;
    int p;
    r = 0;
    case (op)
      32: r = a + b;
      34: r = a - b + 256;
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = 255 - (a | b);
      2: begin
        if (b >= 8) r = 0;
        else r = a / (1 << b);
      end
      3: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) begin
          r = (sa < 0) ? 255 : 0;
        end else begin
          p = 1 << b;
          // floor division of a signed value by 2^b
          if (sa >= 0) r = sa / p;
          else r = -((-sa + p - 1) / p);
        end
      end
      default: r = 0;
    endcase
    return r & 255;
  endfunction

  // Apply inputs for one rising edge and advance the model to match.
  task automatic drive(input int sw, input int btn, input bit rst);
    i_sw    = sw[7:0];
    i_btn   = btn[2:0];
    i_reset = rst;
    @(posedge i_clk);
    if (rst) begin
      exp_led = 0;
      m_a = 0; m_b = 0; m_op = 0;
    end else begin
      exp_led = ref_alu(m_a, m_b, m_op);
      if (btn[0]) m_a  = sw & 255;
      if (btn[1]) m_b  = sw & 255;
      if (btn[2]) m_op = sw & 63;
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    drive(8'h33, 7, 1'b0);
    drive(8'h20, 4, 1'b0);
    drive(8'hA5, 7, 1'b1);
    n_checks++;
    if (o_led !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_led: got %0h want 0", o_led);
    end
    drive(8'h05, 1, 1'b0);
    drive(8'h03, 2, 1'b0);
    drive(8'h00, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_op_cleared: got %0h want 0", o_led);
    end
    drive(8'h00, 7, 1'b1);
    drive(8'h20, 4, 1'b0);
    drive(8'h00, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ab_cleared: got %0h want 0", o_led);
    end
  endtask

  task automatic test_add_sub();
    drive(10, 1, 1'b0);
    drive(5, 2, 1'b0);
    drive(8'h20, 4, 1'b0);
    drive(0, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'd15) begin
      n_fail++;
      $display("FAIL add_10_5: got %0d want 15", o_led);
    end
    drive(15, 1, 1'b0);
    drive(0, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'd20) begin
      n_fail++;
      $display("FAIL add_15_5: got %0d want 20", o_led);
    end
    drive(5, 2, 1'b0);
    drive(8'h22, 4, 1'b0);
    drive(0, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'd10) begin
      n_fail++;
      $display("FAIL sub_15_5: got %0d want 10", o_led);
    end
    drive(5, 1, 1'b0);
    drive(10, 2, 1'b0);
    drive(0, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'd251) begin
      n_fail++;
      $display("FAIL sub_wrap: got %0d want 251", o_led);
    end
  endtask

  task automatic test_logic();
    int ops [4] = '{8'h24, 8'h25, 8'h26, 8'h27};
    logic [7:0] want [4] = '{8'h48, 8'hDE, 8'h96, 8'h21};
    drive(8'hCA, 1, 1'b0);
    drive(8'h5C, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 4, 1'b0);
      drive(0, 0, 1'b0);
      n_checks++;
      if (o_led !== want[i]) begin
        n_fail++;
        $display("FAIL logic_op_%0h: got %0h want %0h", ops[i], o_led, want[i]);
      end
    end
    drive(8'hFF, 1, 1'b0);
    drive(8'h01, 2, 1'b0);
    drive(8'h20, 4, 1'b0);
    drive(0, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'h00) begin
      n_fail++;
      $display("FAIL add_carry_drop: got %0h want 0", o_led);
    end
  endtask

  task automatic test_shift();
    int ops [5] = '{3, 2, 3, 2, 3};
    int amt [5] = '{2, 2, 9, 9, 0};
    logic [7:0] want [5] = '{8'hE4, 8'h24, 8'hFF, 8'h00, 8'h90};
    drive(8'h90, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(amt[i], 2, 1'b0);
      drive(ops[i], 4, 1'b0);
      drive(0, 0, 1'b0);
      n_checks++;
      if (o_led !== want[i]) begin
        n_fail++;
        $display("FAIL shift_op%0d_b%0d: got %0h want %0h", ops[i], amt[i], o_led, want[i]);
      end
    end
    drive(0, 4, 1'b0);
    drive(2, 4, 1'b0);
    drive(0, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'h90) begin
      n_fail++;
      $display("FAIL srl_b0: got %0h want 90", o_led);
    end
  endtask

  task automatic test_loads();
    int prev;
    int cur;
    drive(8'h3F, 4, 1'b0);
    drive(0, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'h00) begin
      n_fail++;
      $display("FAIL invalid_op: got %0h want 0", o_led);
    end
    drive(7, 3, 1'b0);
    drive(8'h20, 4, 1'b0);
    drive(0, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'd14) begin
      n_fail++;
      $display("FAIL dual_load_add: got %0d want 14", o_led);
    end
    drive(8'h10, 2, 1'b0);
    prev = $urandom_range(0, 255);
    drive(prev, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cur = $urandom_range(0, 255);
      drive(cur, 1, 1'b0);
      n_checks++;
      if (o_led !== 8'((prev + 16) % 256)) begin
        n_fail++;
        $display("FAIL hold_track_%0d: got %0h want %0h", i, o_led, (prev + 16) % 256);
      end
      prev = cur;
    end
    drive(8'hAA, 0, 1'b0);
    drive(8'h55, 0, 1'b0);
    n_checks++;
    if (o_led !== 8'((prev + 16) % 256)) begin
      n_fail++;
      $display("FAIL release_hold: got %0h want %0h", o_led, (prev + 16) % 256);
    end
  endtask

  task automatic test_random();
    int valid [8] = '{32, 34, 36, 37, 38, 39, 3, 2};
    int sw;
    int btn;
    bit rst;
    for (int i = 0; i < 300; i++) begin
      btn = $urandom_range(0, 7);
      sw  = $urandom_range(0, 255);
      if (btn[2] && $urandom_range(0, 3) != 0) sw = valid[$urandom_range(0, 7)];
      if (btn[1] && $urandom_range(0, 3) == 0) sw = $urandom_range(0, 12);
      rst = ($urandom_range(0, 39) == 0);
      drive(sw, btn, rst);
      n_checks++;
      if (o_led !== exp_led[7:0]) begin
        n_fail++;
        $display("FAIL random_%0d: got %0h want %0h (a=%0h b=%0h op=%0h)",
                 i, o_led, exp_led, m_a, m_b, m_op);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_a = 0; m_b = 0; m_op = 0; exp_led = 0;
    i_reset = 1'b1;
    i_sw    = 8'h00;
    i_btn   = 3'b000;
    @(negedge i_clk);
    drive(0, 0, 1'b1);
    test_reset();
    test_add_sub();
    test_logic();
    test_shift();
    test_loads();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
